// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM fade controller: state encoding, default prescaler
// and the per-tick level approach rule.
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    DONE = 2'd2
  } fade_state_t;

  // 255 makes one level update per 256-cycle (8-bit) PWM period.
  localparam int unsigned PRESC_DEFAULT = 255;

  function automatic logic [7:0] step_norm(input logic [7:0] s);
    return (s == 8'd0) ? 8'd1 : s;
  endfunction

  // Moves lvl toward tgt by stp, landing exactly on tgt when closer than one step.
  function automatic logic [7:0] step_toward(input logic [7:0] lvl,
                                             input logic [7:0] tgt,
                                             input logic [7:0] stp);
    logic [7:0] res;
    res = lvl;
    if (lvl < tgt) begin
      res = ((tgt - lvl) <= stp) ? tgt : lvl + stp;
    end else if (lvl > tgt) begin
      res = ((lvl - tgt) <= stp) ? tgt : lvl - stp;
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_gamma_lut.sv
// Perceptual (gamma ~2) duty table, 256 entries: round(i*i/255); only built with
// PWM_FADE_GAMMA_EN so the default build carries no unused module.
`ifdef PWM_FADE_GAMMA_EN
module pwm_gamma_lut (
  input  logic [7:0] idx,
  output logic [7:0] val
);

  logic [15:0] sq;
  logic [15:0] scaled;

  assign sq     = {8'd0, idx} * {8'd0, idx};
  assign scaled = (sq + 16'd127) / 16'd255;
  assign val    = scaled[7:0];

endmodule
`endif

// File: rtl/pwm_fade_ctrl.sv
// Fades a registered PWM duty word toward a target level, one step every PRESC+1 cycles.
// Define PWM_FADE_GAMMA_EN to map the level through pwm_gamma_lut before it reaches duty.
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned PRESC = PRESC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] target,
  input  logic [7:0] step,
  output logic [7:0] duty,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = (PRESC > 0) ? $clog2(PRESC + 1) : 1;

  fade_state_t   state, state_nxt;
  logic [7:0]    level, level_nxt;
  logic [7:0]    tgt, tgt_nxt;
  logic [7:0]    stp, stp_nxt;
  logic [7:0]    duty_map;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          tick;

  assign tick = (state == RAMP) && (cnt == CW'(PRESC));

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    tgt_nxt   = tgt;
    stp_nxt   = stp;
    cnt_nxt   = cnt;
    case (state)
      RAMP: begin
        cnt_nxt = tick ? '0 : cnt + CW'(1);
        if (tick) begin
          level_nxt = step_toward(level, tgt, stp);
        end
        // A new request mid-fade replaces the goal and suppresses completion this cycle.
        if (start) begin
          tgt_nxt = target;
          stp_nxt = step_norm(step);
        end else if (level == tgt) begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        if (start) begin
          tgt_nxt   = target;
          stp_nxt   = step_norm(step);
          cnt_nxt   = '0;
          state_nxt = RAMP;
        end
      end
    endcase
  end

`ifdef PWM_FADE_GAMMA_EN
  pwm_gamma_lut u_gamma (
    .idx (level_nxt),
    .val (duty_map)
  );
`else
  assign duty_map = level_nxt;
`endif

  // duty is loaded from the next level so it changes on the same edge as level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      level <= 8'd0;
      tgt   <= 8'd0;
      stp   <= 8'd0;
      cnt   <= '0;
      duty  <= 8'd0;
    end else begin
      state <= state_nxt;
      level <= level_nxt;
      tgt   <= tgt_nxt;
      stp   <= stp_nxt;
      cnt   <= cnt_nxt;
      duty  <= duty_map;
    end
  end

  assign busy = (state == RAMP);
  assign done = (state == DONE);

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl (PRESC=3): cycle-level reference model plus directed scenarios.
module tb_pwm_fade_ctrl;

  localparam int P = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] target = 8'd0;
  logic [7:0] step = 8'd0;
  logic [7:0] duty;
  logic       busy;
  logic       done;

  pwm_fade_ctrl #(.PRESC(P)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .target (target),
    .step   (step),
    .duty   (duty),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 fading, 2 completion cycle.
  int m_phase = 0, m_level = 0, m_tgt = 0, m_stp = 0, m_cnt = 0;
  int m_reached;

  function automatic int toward(input int lvl, input int tgt, input int stp);
    int d;
    d = tgt - lvl;
    if (d > stp) return lvl + stp;
    if (d < -stp) return lvl - stp;
    return tgt;
  endfunction

  function automatic int exp_duty(input int l);
`ifdef PWM_FADE_GAMMA_EN
    real r;
    r = 255.0 * (l / 255.0) * (l / 255.0);
    return $rtoi(r + 0.5);
`else
    return l;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_level = 0; m_tgt = 0; m_stp = 0; m_cnt = 0;
    end else if (m_phase == 1) begin
      m_reached = (m_level == m_tgt);
      if (m_cnt == P) begin
        m_cnt = 0;
        m_level = toward(m_level, m_tgt, m_stp);
      end else begin
        m_cnt++;
      end
      if (start) begin
        m_tgt = target;
        m_stp = (step == 0) ? 1 : int'(step);
      end else if (m_reached != 0) begin
        m_phase = 2;
      end
    end else if (start) begin
      m_tgt = target;
      m_stp = (step == 0) ? 1 : int'(step);
      m_cnt = 0;
      m_phase = 1;
    end else begin
      m_phase = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_duty", duty, exp_duty(m_level));
      check("model_busy", busy, (m_phase == 1) ? 1 : 0);
      check("model_done", done, (m_phase == 2) ? 1 : 0);
    end
  end

  logic [7:0] chg_v[$];
  int         chg_c[$];
  int         stray_done = 0;

  task automatic do_start(input logic [7:0] t, input logic [7:0] s);
    @(posedge clk); #1;
    start = 1'b1; target = t; step = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_start_now(input logic [7:0] t, input logic [7:0] s);
    start = 1'b1; target = t; step = s;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records duty changes until done; returns the cycle index of done (-1 on timeout).
  task automatic wait_done(input int budget, output int done_c);
    logic [7:0] prev;
    chg_v.delete();
    chg_c.delete();
    prev = duty;
    done_c = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (duty != prev) begin
        chg_v.push_back(duty);
        chg_c.push_back(c);
      end
      prev = duty;
      if (done) begin
        done_c = c;
        break;
      end
    end
    if (done_c < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      @(negedge clk);
      check("done_single", done, 0);
      check("busy_after_done", busy, 0);
    end
  endtask

  task automatic wait_duty(input int v, input int budget);
    int seen;
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) stray_done++;
      if (duty == v) begin
        seen = 1;
        break;
      end
    end
    check("reach_duty", seen, 1);
  endtask

  int dc;
  int lvl_at;
  int nwait;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Ramp up 0 -> 10 by 4.
    do_start(8'd10, 8'd4);
    wait_done(200, dc);
    check("up_nchg", chg_v.size(), 3);
    if (chg_v.size() == 3) begin
      check("up_v0", chg_v[0], 4);
      check("up_v1", chg_v[1], 8);
      check("up_v2", chg_v[2], 10);
      check("up_c0", chg_c[0], 5);
      check("up_gap1", chg_c[1] - chg_c[0], 4);
      check("up_gap2", chg_c[2] - chg_c[1], 4);
    end
    check("up_done_cycle", dc, 14);

    // Target equal to current level: done two cycles after start.
    do_start(8'd10, 8'd4);
    wait_done(20, dc);
    check("eq_nchg", chg_v.size(), 0);
    check("eq_done_cycle", dc, 2);

    // Ramp down 10 -> 0 by 3 with no underflow.
    do_start(8'd0, 8'd3);
    wait_done(200, dc);
    check("dn_nchg", chg_v.size(), 4);
    if (chg_v.size() == 4) begin
      check("dn_v0", chg_v[0], 7);
      check("dn_v1", chg_v[1], 4);
      check("dn_v2", chg_v[2], 1);
      check("dn_v3", chg_v[3], 0);
    end

    // Step 0 behaves as step 1.
    do_start(8'd200, 8'd0);
    wait_done(1000, dc);
    check("s0_nchg", chg_v.size(), 200);
    if (chg_v.size() == 200) begin
      check("s0_v0", chg_v[0], 1);
      check("s0_v1", chg_v[1], 2);
      check("s0_v2", chg_v[2], 3);
      check("s0_last", chg_v[199], 200);
    end

    // Reversal mid-fade: only the final target produces done.
    do_start(8'd0, 8'd255);
    wait_done(50, dc);
    check("jump0", duty, 0);
    stray_done = 0;
    do_start(8'd100, 8'd7);
    wait_duty(35, 200);
    lvl_at = duty;
    do_start(8'd20, 8'd7);
    wait_done(200, dc);
    check("rev_stray_done", stray_done, 0);
    if (chg_v.size() > 0) check("rev_first", chg_v[0], lvl_at - 7);
    else check("rev_nchg", 0, 1);
    check("rev_final", duty, 20);

    // Randomized requests, including restarts mid-fade and in the done cycle.
    for (int i = 0; i < 40; i++) begin
      if (done && ($urandom_range(0, 1) == 1)) do_start_now(8'($urandom_range(0, 255)), 8'($urandom_range(0, 40)));
      else do_start(8'($urandom_range(0, 255)), 8'($urandom_range(0, 40)));
      nwait = $urandom_range(0, 80);
      for (int c = 0; c < nwait; c++) begin
        @(negedge clk);
        if (done) break;
      end
    end
    repeat (20) @(negedge clk);

    // Asynchronous reset mid-fade at level 50.
    do_start(8'd0, 8'd255);
    wait_done(50, dc);
    stray_done = 0;
    do_start(8'd200, 8'd10);
    wait_duty(50, 200);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_duty", duty, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done || busy) stray_done++;
    end
    check("arst_no_done", stray_done, 0);

    // Full-scale jumps (same endpoints with or without gamma).
    do_start(8'd255, 8'd255);
    wait_done(50, dc);
    check("full_up", duty, 255);
    do_start(8'd0, 8'd255);
    wait_done(50, dc);
    check("full_dn", duty, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
